gray_step_decoder: RTL and testbench
====================================

// Module: gray_step_decoder
// PURPOSE
//  Receive end of the team's Gray-counter interface. Takes an asynchronous
//  N-bit Gray code from a Gray counter or position sensor, synchronizes it,
//  and converts it to binary. Classifies each change as +1, -1 or an illegal
//  skip, and keeps a signed position accumulator plus a saturating error count.
//  Sits between a Gray source in another clock domain and local control logic.
// PARAMETERS
//  N            4   Gray/binary code width; legal range is N >= 2
//  POS_W        16  width of the position accumulator (two's complement)
//  SYNC_STAGES  2   synchronizer flop stages on gray_in; legal range is >= 2
// PORTS
//  clk         in   1        single clock, rising-edge
//  reset       in   1        asynchronous, active-high; clears all state
//  gray_in     in   N        Gray code, asynchronous to clk
//  clear       in   1        sync; zeroes position and err_count
//  binary_out  out  N        registered binary value of the synchronized code
//  valid       out  1        high once a baseline value is captured
//  step_up     out  1        1-cycle pulse: code advanced by +1 (mod 2^N)
//  step_down   out  1        1-cycle pulse: code retreated by 1 (mod 2^N)
//  skip_err    out  1        1-cycle pulse: code changed by more than 1
//  position    out  POS_W    signed net step count
//  err_count   out  8        skip_err count, saturating at 255
// BEHAVIOUR
//  Reset values
//   - All outputs are 0.
//   - Sync flops are 0.
//   - FSM is in INIT with the flush counter at 0.
//  Datapath
//   - gray_in passes through SYNC_STAGES flops to give gs.
//   - bin_cur = gray_to_bin(gs), combinational.
//   - Multi-bit sync is safe because legal Gray changes flip exactly one bit.
//  FSM INIT
//   - Counts SYNC_STAGES cycles to flush the reset zeros out of the sync chain.
//   - On the next edge: binary_out <= bin_cur, valid <= 1, go to TRACK.
//   - No step or error pulses are produced in INIT.
//  FSM TRACK (every edge)
//   - delta = bin_cur - binary_out, computed mod 2^N.
//   - delta == 0: no pulse.
//   - delta == 1: step_up; position += 1.
//   - delta == 2^N-1: step_down; position -= 1.
//   - Any other delta: skip_err; err_count += 1 (saturating); position
//     unchanged. binary_out still takes bin_cur, so tracking resynchronizes.
//   - binary_out <= bin_cur on every edge.
//  Timing and wrap-around
//   - Latency: a gray_in change settled before edge k appears on binary_out
//     and the pulses at edge k+SYNC_STAGES.
//   - Wrap of the code: 2^N-1 -> 0 is step_up; 0 -> 2^N-1 is step_down.
//   - position wraps mod 2^POS_W with no saturation.
//  Simultaneous events and reset
//   - clear has priority over a same-cycle step or error: position and
//     err_count go to 0. The pulses still fire and binary_out still updates.
//   - clear does not affect valid, the FSM or binary_out.
//   - Reset mid-operation: immediate asynchronous return to reset values;
//     valid goes high again SYNC_STAGES+1 edges after reset deasserts.
// STRUCTURE
//  Package gray_pkg:
//   - function gray_to_bin(gray) (XOR-prefix), parameterized by width
//   - localparams ST_INIT = 1'b0, ST_TRACK = 1'b1
//   - localparam ERR_MAX = 8'd255
//  Sub-module gray_sync:
//   - N-bit, SYNC_STAGES-deep flop chain with async reset to 0
//   - Instantiated once.
//  Top level: FSM, delta classification, accumulators.
// TESTING (N=4, POS_W=16, SYNC_STAGES=2)
//  1. Reset, gray_in=4'b0000 held -> valid=1 at 3rd edge after deassert;
//     binary_out=0; no pulses.
//  2. Drive the Gray sequence for binary 0..15 then 0, one value per 4 clocks
//     -> 16 step_up pulses; position=16; binary_out goes 15->0.
//  3. Drive binary 3 (4'b0010) then binary 2 (4'b0011) -> one step_down
//     pulse; position decreases by 1.
//  4. Baseline 0, drive 4'b0011 (bin 2) -> skip_err; err_count=1; position
//     unchanged. Then drive 4'b0010 (bin 3) -> step_up.
//  5. Assert clear on the same edge as a step_up -> step_up pulses;
//     position=0; err_count=0.
//  6. Reach position=5, assert reset asynchronously -> all outputs 0
//     immediately; valid=0 until SYNC_STAGES+1 edges after deassert.
//     Then force 300 skips -> err_count holds at 255.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: shared state encoding, error ceiling and Gray-to-binary conversion
package gray_pkg;
  localparam int GMAX = 32;
  localparam logic [7:0] ERR_MAX = 8'd255;
  typedef enum logic {ST_INIT = 1'b0, ST_TRACK = 1'b1} state_t;
  function automatic logic [GMAX-1:0] gray_to_bin(input logic [GMAX-1:0] gray);
    logic [GMAX-1:0] b;
    b[GMAX-1] = gray[GMAX-1];
    for (int i = GMAX - 2; i >= 0; i--) b[i] = b[i+1] ^ gray[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_step_decoder_if.sv
// gray_step_decoder_if: Gray input, clear and decoded step/position outputs
interface gray_step_decoder_if #(parameter int N = 4, parameter int POS_W = 16);
  logic [N-1:0] gray_in;
  logic clear;
  logic [N-1:0] binary_out;
  logic valid;
  logic step_up;
  logic step_down;
  logic skip_err;
  logic [POS_W-1:0] position;
  logic [7:0] err_count;
  modport master(output gray_in, clear, input binary_out, valid, step_up, step_down, skip_err, position, err_count);
  modport slave(input gray_in, clear, output binary_out, valid, step_up, step_down, skip_err, position, err_count);
endinterface

// File: rtl/gray_sync.sv
// gray_sync: multi-stage synchronizer for a Gray code crossing into clk
module gray_sync #(
  parameter int N = 4,
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [N-1:0] r [STAGES];
  // shift the asynchronous code through the chain; only one bit flips per legal change
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < STAGES; i++) r[i] <= '0;
    else begin
      r[0] <= d;
      for (int i = 1; i < STAGES; i++) r[i] <= r[i-1];
    end
  assign q = r[STAGES-1];
endmodule

// File: rtl/gray_step_decoder.sv
// gray_step_decoder: synchronizes a Gray code and tracks steps, position and skip errors
module gray_step_decoder
  import gray_pkg::*;
#(
  parameter int N = 4,
  parameter int POS_W = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  gray_step_decoder_if.slave bus
);
  localparam int CW = $clog2(SYNC_STAGES + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0] gs, bin_cur, delta, bin_n;
  logic valid_n, up_n, dn_n, sk_n;
  logic [POS_W-1:0] pos_n;
  logic [7:0] err_n;
  gray_sync #(.N(N), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .d(bus.gray_in),
    .q(gs)
  );
  assign bin_cur = N'(gray_to_bin(GMAX'(gs)));
  assign delta = bin_cur - bus.binary_out;
  // INIT flushes reset zeros from the sync chain before taking a baseline; TRACK classifies each delta
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bin_n = bus.binary_out;
    valid_n = bus.valid;
    up_n = 1'b0;
    dn_n = 1'b0;
    sk_n = 1'b0;
    pos_n = bus.position;
    err_n = bus.err_count;
    if (state == ST_INIT) begin
      if (cnt == CW'(SYNC_STAGES)) begin
        state_n = ST_TRACK;
        bin_n = bin_cur;
        valid_n = 1'b1;
      end else cnt_n = cnt + 1'b1;
    end else begin
      bin_n = bin_cur;
      up_n = delta == N'(1);
      dn_n = delta == '1;
      sk_n = delta != '0 && !up_n && !dn_n;
      pos_n = up_n ? bus.position + 1'b1 : dn_n ? bus.position - 1'b1 : bus.position;
      err_n = sk_n && bus.err_count != ERR_MAX ? bus.err_count + 1'b1 : bus.err_count;
    end
    if (bus.clear) begin
      pos_n = '0;
      err_n = '0;
    end
  end
  // register FSM, decoded value, pulses and accumulators
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_INIT;
      cnt <= '0;
      bus.binary_out <= '0;
      bus.valid <= 1'b0;
      bus.step_up <= 1'b0;
      bus.step_down <= 1'b0;
      bus.skip_err <= 1'b0;
      bus.position <= '0;
      bus.err_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bus.binary_out <= bin_n;
      bus.valid <= valid_n;
      bus.step_up <= up_n;
      bus.step_down <= dn_n;
      bus.skip_err <= sk_n;
      bus.position <= pos_n;
      bus.err_count <= err_n;
    end
endmodule

// File: tb/tb_gray_step_decoder.sv
// tb_gray_step_decoder: scoreboard bench with a step-arithmetic reference model
module tb_gray_step_decoder;
  localparam int N = 4, POS_W = 16, SS = 2;
  typedef struct {
    logic [2:0] kind;
    logic [3:0] bin;
    logic [15:0] pos;
    logic [7:0] err;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int m_bin = 0, m_err = 0;
  logic [15:0] m_pos = '0;
  int lat;
  always #5 clk = ~clk;
  gray_step_decoder_if #(.N(N), .POS_W(POS_W)) bus ();
  gray_step_decoder #(.N(N), .POS_W(POS_W), .SYNC_STAGES(SS)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // monitor: every pulse must match the oldest expected event
  always @(negedge clk)
    if (!reset && (bus.step_up || bus.step_down || bus.skip_err)) begin
      if (q.size() == 0) chk("unexpected_pulse", {29'd0, bus.step_up, bus.step_down, bus.skip_err}, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", {29'd0, bus.step_up, bus.step_down, bus.skip_err}, {29'd0, e.kind});
        chk("binary_out", {28'd0, bus.binary_out}, {28'd0, e.bin});
        chk("position", {16'd0, bus.position}, {16'd0, e.pos});
        chk("err_count", {24'd0, bus.err_count}, {24'd0, e.err});
        chk("valid", {31'd0, bus.valid}, 32'd1);
      end
    end
  task automatic step_to(input int b, input int hold = 4, input bit clr = 1'b0);
    int d;
    exp_t e;
    d = (b - m_bin) & 15;
    bus.gray_in = 4'(b ^ (b >> 1));
    if (d != 0) begin
      if (d == 1) begin m_pos = m_pos + 16'd1; e.kind = 3'b100; end
      else if (d == 15) begin m_pos = m_pos - 16'd1; e.kind = 3'b010; end
      else begin m_err = m_err < 255 ? m_err + 1 : 255; e.kind = 3'b001; end
      if (clr) begin m_pos = '0; m_err = 0; end
      m_bin = b;
      e.bin = 4'(b);
      e.pos = m_pos;
      e.err = 8'(m_err);
      q.push_back(e);
    end
    if (clr) begin
      repeat (2) @(posedge clk);
      #1 bus.clear = 1'b1;
      @(posedge clk);
      #1 bus.clear = 1'b0;
      repeat (hold - 3) @(posedge clk);
    end else repeat (hold) @(posedge clk);
    #1;
    chk("pending_events", q.size(), 32'd0);
    q.delete();
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_bin"}, {28'd0, bus.binary_out}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.valid}, 32'd0);
    chk({tag, "_pulses"}, {29'd0, bus.step_up, bus.step_down, bus.skip_err}, 32'd0);
    chk({tag, "_pos"}, {16'd0, bus.position}, 32'd0);
    chk({tag, "_err"}, {24'd0, bus.err_count}, 32'd0);
  endtask
  task automatic release_reset();
    q.delete();
    m_pos = '0;
    m_err = 0;
    for (int b = 0; b < 16; b++) if (4'(b ^ (b >> 1)) == bus.gray_in) m_bin = b;
    @(posedge clk);
    #1 reset = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid && lat == 0) lat = i;
    end
    chk("valid_latency", lat, SS + 1);
    chk("baseline_bin", {28'd0, bus.binary_out}, m_bin);
  endtask
  initial begin
    bus.gray_in = '0;
    bus.clear = 1'b0;
    #12;
    check_zero("reset");
    release_reset();
    for (int b = 1; b < 16; b++) step_to(b);
    step_to(0);
    chk("pos_after_wrap", {16'd0, bus.position}, 32'd16);
    step_to(3);
    step_to(2);
    step_to(0);
    step_to(2);
    step_to(3);
    step_to(4, 4, 1'b1);
    chk("clear_pos", {16'd0, bus.position}, 32'd0);
    chk("clear_err", {24'd0, bus.err_count}, 32'd0);
    for (int i = 0; i < 200; i++) begin
      int r, b;
      r = $urandom_range(0, 9);
      b = r < 4 ? (m_bin + 1) & 15 : r < 7 ? (m_bin + 15) & 15 : int'($urandom_range(0, 15));
      step_to(b, $urandom_range(4, 6), $urandom_range(0, 9) == 0);
    end
    step_to((m_bin + 1) & 15, 4, 1'b1);
    for (int i = 0; i < 5; i++) step_to((m_bin + 1) & 15);
    chk("pos_five", {16'd0, bus.position}, 32'd5);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_zero("async_reset");
    repeat (3) @(posedge clk);
    release_reset();
    for (int i = 0; i < 300; i++) step_to((m_bin + 8) & 15);
    chk("err_saturated", {24'd0, bus.err_count}, 32'd255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
